// File: rtl/chacha_seq_pkg.sv
// Shared types and constants for the ChaCha block-request sequencer.
package chacha_seq_pkg;

   localparam int DEF_CNTR_WIDTH = 32;
   localparam int DEF_LEN_WIDTH  = 16;

   localparam logic [DEF_CNTR_WIDTH-1:0] CTR_MAX = '1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DONE  = 2'd2
   } seq_state_e;

endpackage

// File: rtl/chacha_block_seq_if.sv
// Job and block-request handshake bundle between the sequencer and its environment.
interface chacha_block_seq_if #(
   parameter int CNTR_WIDTH = 32,
   parameter int LEN_WIDTH  = 16
);
   logic                  job_valid;
   logic                  job_ready;
   logic [CNTR_WIDTH-1:0] job_ctr_init;
   logic [LEN_WIDTH-1:0]  job_nblocks;
   logic                  job_allow_wrap;

   logic                  blk_valid;
   logic                  blk_ready;
   logic [CNTR_WIDTH-1:0] blk_ctr;
   logic                  blk_last;

   logic                  busy;
   logic                  done;
   logic                  err_wrap;

   // master: the sequencer producing block requests
   modport master (
      input  job_valid, job_ctr_init, job_nblocks, job_allow_wrap, blk_ready,
      output job_ready, blk_valid, blk_ctr, blk_last, busy, done, err_wrap
   );

   // slave: job source and ChaCha core consuming requests
   modport slave (
      output job_valid, job_ctr_init, job_nblocks, job_allow_wrap, blk_ready,
      input  job_ready, blk_valid, blk_ctr, blk_last, busy, done, err_wrap
   );
endinterface

// File: rtl/chacha_seq_ctr.sv
// Loadable up/down counter with a terminal-value compare output.
module chacha_seq_ctr #(
   parameter int               WIDTH = 32,
   parameter bit               UP    = 1'b1,
   parameter logic [WIDTH-1:0] TERM  = '1
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_val,
   input  logic             i_en,
   output logic [WIDTH-1:0] o_val,
   output logic             o_at_term
);

   logic [WIDTH-1:0] r_val;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_val <= '0;
      end else if (i_load) begin
         r_val <= i_load_val;
      end else if (i_en) begin
         r_val <= UP ? r_val + WIDTH'(1) : r_val - WIDTH'(1);
      end
   end

   assign o_val     = r_val;
   assign o_at_term = (r_val == TERM);

endmodule

// File: rtl/chacha_block_seq.sv
// Turns a keystream job into one block request per cycle for the ChaCha core.
//
// state    | meaning
// ST_IDLE  | waiting for a job, job_ready high
// ST_ISSUE | presenting blk_ctr/blk_last until the core takes each block
// ST_DONE  | one-cycle done pulse, err_wrap if the job hit a forbidden wrap
module chacha_block_seq
   import chacha_seq_pkg::*;
#(
   parameter int CNTR_WIDTH = DEF_CNTR_WIDTH,
   parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
   input  logic               i_clk,
   input  logic               i_reset,
   chacha_block_seq_if.master if_seq
);

   seq_state_e            r_state;
   seq_state_e            w_state_nxt;
   logic                  r_allow_wrap;
   logic                  r_err_flag;

   logic                  w_load;
   logic                  w_adv;
   logic                  w_set_err;
   logic [CNTR_WIDTH-1:0] w_ctr;
   logic                  w_ctr_max;
   logic [LEN_WIDTH-1:0]  w_rem;
   logic                  w_rem_one;

   chacha_seq_ctr #(
      .WIDTH (CNTR_WIDTH),
      .UP    (1'b1),
      .TERM  ('1)
   ) u_ctr (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_load     (w_load),
      .i_load_val (if_seq.job_ctr_init),
      .i_en       (w_adv),
      .o_val      (w_ctr),
      .o_at_term  (w_ctr_max)
   );

   // remaining-block count; terminal value 1 marks the last block
   chacha_seq_ctr #(
      .WIDTH (LEN_WIDTH),
      .UP    (1'b0),
      .TERM  (LEN_WIDTH'(1))
   ) u_rem (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_load     (w_load),
      .i_load_val (if_seq.job_nblocks),
      .i_en       (w_adv),
      .o_val      (w_rem),
      .o_at_term  (w_rem_one)
   );

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_adv       = 1'b0;
      w_set_err   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (if_seq.job_valid) begin
               w_load      = 1'b1;
               w_state_nxt = (if_seq.job_nblocks == '0) ? ST_DONE : ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (if_seq.blk_ready) begin
               if (w_rem_one) begin
                  w_state_nxt = ST_DONE;
               end else if (w_ctr_max && !r_allow_wrap) begin
                  // drop the rest of the job rather than reuse counter values
                  w_set_err   = 1'b1;
                  w_state_nxt = ST_DONE;
               end else begin
                  w_adv = 1'b1;
               end
            end
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_allow_wrap <= 1'b0;
         r_err_flag   <= 1'b0;
      end else begin
         if (w_load) begin
            r_allow_wrap <= if_seq.job_allow_wrap;
         end
         if (w_set_err) begin
            r_err_flag <= 1'b1;
         end else if (r_state == ST_DONE) begin
            r_err_flag <= 1'b0;
         end
      end
   end

   assign if_seq.job_ready = (r_state == ST_IDLE);
   assign if_seq.blk_valid = (r_state == ST_ISSUE);
   assign if_seq.blk_ctr   = (r_state == ST_ISSUE) ? w_ctr : '0;
   assign if_seq.blk_last  = (r_state == ST_ISSUE) && w_rem_one;
   assign if_seq.busy      = (r_state != ST_IDLE);
   assign if_seq.done      = (r_state == ST_DONE);
   assign if_seq.err_wrap  = (r_state == ST_DONE) && r_err_flag;

endmodule

// File: tb/tb_chacha_block_seq.sv
// Randomized and directed checks of the block sequencer against a job-level model.
module tb_chacha_block_seq;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   chacha_block_seq_if bus ();

   chacha_block_seq dut (
      .i_clk   (clk),
      .i_reset (rst),
      .if_seq  (bus)
   );

   int total = 0;
   int bad   = 0;

   logic [31:0] exp_q[$];
   bit          exp_err;
   int          exp_n;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Expected block counters: consecutive values from init, stopping at a forbidden wrap.
   task automatic model(input logic [31:0] init, input int n, input bit wrap);
      logic [63:0] v;
      exp_q.delete();
      exp_err = 1'b0;
      exp_n   = n;
      for (int i = 0; i < n; i++) begin
         v = {32'h0, init} + 64'(i);
         if (v > 64'hFFFF_FFFF && !wrap) begin
            exp_err = 1'b1;
            break;
         end
         exp_q.push_back(v[31:0]);
      end
   endtask

   task automatic start_job(input logic [31:0] init, input int n, input bit wrap);
      @(negedge clk);
      bus.job_valid      = 1'b1;
      bus.job_ctr_init   = init;
      bus.job_nblocks    = 16'(n);
      bus.job_allow_wrap = wrap;
      @(posedge clk);
   endtask

   // mode 0: ready always, 1: pattern 1,0,0,1,1, 2: random
   task automatic follow_job(input int mode);
      int idx = 0;
      int k   = 0;
      bit fin = 1'b0;
      bit rdy;
      bit pat[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         bus.job_valid = 1'b0;
         if (idx < exp_q.size()) begin
            check("blk_valid", bus.blk_valid, 1);
            check("blk_ctr", bus.blk_ctr, exp_q[idx]);
            check("blk_last", bus.blk_last, (idx == exp_n - 1));
            check("done_early", bus.done, 0);
            check("job_ready_busy", bus.job_ready, 0);
            check("busy", bus.busy, 1);
            if (mode == 0)      rdy = 1'b1;
            else if (mode == 1) rdy = pat[k % 5];
            else                rdy = 1'($urandom_range(0, 1));
            k++;
            bus.blk_ready = rdy;
            if (rdy) idx++;
         end else begin
            check("done", bus.done, 1);
            check("err_wrap", bus.err_wrap, exp_err);
            check("blk_valid_done", bus.blk_valid, 0);
            check("job_ready_done", bus.job_ready, 0);
            bus.blk_ready = 1'($urandom_range(0, 1));
            fin = 1'b1;
            break;
         end
      end
      check("job_finished_in_budget", fin, 1);
      @(negedge clk);
      check("done_cleared", bus.done, 0);
      check("err_cleared", bus.err_wrap, 0);
      check("job_ready_idle", bus.job_ready, 1);
      check("busy_idle", bus.busy, 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_job_ready"}, bus.job_ready, 1);
      check({tag, "_blk_valid"}, bus.blk_valid, 0);
      check({tag, "_blk_ctr"}, bus.blk_ctr, 0);
      check({tag, "_blk_last"}, bus.blk_last, 0);
      check({tag, "_busy"}, bus.busy, 0);
      check({tag, "_done"}, bus.done, 0);
      check({tag, "_err_wrap"}, bus.err_wrap, 0);
   endtask

   initial begin
      logic [31:0] r_init;
      int          r_n;
      bit          r_wrap;

      rst                = 1'b1;
      bus.job_valid      = 1'b0;
      bus.job_ctr_init   = '0;
      bus.job_nblocks    = '0;
      bus.job_allow_wrap = 1'b0;
      bus.blk_ready      = 1'b0;
      #1;
      check_reset_outputs("reset");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_reset_outputs("post_reset");

      model(32'd5, 3, 1'b0);
      start_job(32'd5, 3, 1'b0);
      follow_job(0);

      model(32'd5, 3, 1'b0);
      start_job(32'd5, 3, 1'b0);
      follow_job(1);

      model(32'hFFFF_FFFE, 4, 1'b0);
      start_job(32'hFFFF_FFFE, 4, 1'b0);
      follow_job(0);

      model(32'hFFFF_FFFE, 4, 1'b1);
      start_job(32'hFFFF_FFFE, 4, 1'b1);
      follow_job(0);

      // zero-length job with job_valid held through DONE
      start_job(32'd0, 0, 1'b0);
      @(negedge clk);
      check("zero_done", bus.done, 1);
      check("zero_no_blk", bus.blk_valid, 0);
      check("zero_job_ready", bus.job_ready, 0);
      check("zero_err", bus.err_wrap, 0);
      bus.job_ctr_init = 32'd9;
      bus.job_nblocks  = 16'd2;
      @(negedge clk);
      check("held_not_taken_ready", bus.job_ready, 1);
      check("held_not_taken_busy", bus.busy, 0);
      check("held_no_done", bus.done, 0);
      model(32'd9, 2, 1'b0);
      @(posedge clk);
      follow_job(0);

      // reset while block 2 of 4 is presented
      start_job(32'd100, 4, 1'b0);
      @(negedge clk);
      bus.job_valid = 1'b0;
      check("rst_blk1", bus.blk_ctr, 100);
      bus.blk_ready = 1'b1;
      @(negedge clk);
      check("rst_blk2", bus.blk_ctr, 101);
      rst = 1'b1;
      #1;
      check_reset_outputs("mid_reset");
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("mid_reset_no_done", bus.done, 0);
         check("mid_reset_no_blk", bus.blk_valid, 0);
      end
      rst = 1'b0;
      model(32'd200, 4, 1'b0);
      start_job(32'd200, 4, 1'b0);
      follow_job(2);

      for (int j = 0; j < 24; j++) begin
         if ($urandom_range(0, 1) == 1) r_init = 32'hFFFF_FFFF - 32'($urandom_range(0, 5));
         else                          r_init = $urandom;
         r_n    = $urandom_range(0, 7);
         r_wrap = 1'($urandom_range(0, 1));
         model(r_init, r_n, r_wrap);
         start_job(r_init, r_n, r_wrap);
         follow_job($urandom_range(0, 2));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
